sequence_generator_serial: RTL and testbench

//  Serial pattern transmitter: on a start request it emits a fixed PAT_W-bit

---
 rtl/sequence_generator_serial.sv | 168 ++++++++++++++++
 tb/tb_sequence_generator_serial.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_generator_serial.sv
// Serial pattern transmitter.
// Sends a fixed PAT_W-bit pattern MSB-first, one bit per clock, repeated
// rep_cnt times with IDLE_GAP idle cycles between repetitions. Every output
// is a flop fed from the next-state logic, so there is no combinational
// path from any input to any output.
module sequence_generator_serial #(
    parameter int                PAT_W    = 4,
    parameter logic [PAT_W-1:0]  PATTERN  = 4'b1011,
    parameter int                CNT_W    = 8,
    parameter int                IDLE_GAP = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_cnt,
    input  logic             abort,
    output logic             out,
    output logic             out_valid,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(PAT_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [3:0]       GAP_LOAD = 4'(IDLE_GAP - 1);
    localparam bit               HAS_GAP  = (IDLE_GAP > 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state, state_n;
    // bit_idx is the pattern position currently being driven on out.
    logic [IDX_W-1:0]   bit_idx, bit_idx_n;
    // reps_left includes the repetition currently on the wire.
    logic [CNT_W-1:0]   reps_left, reps_left_n;
    // gap_cnt counts remaining idle cycles after the current one.
    logic [3:0]         gap_cnt, gap_cnt_n;
    logic               out_n, out_valid_n, last_n, busy_n, done_n;

    // Pattern bit at a given position; isolated so the shift index math
    // stays readable.
    function automatic logic pat_bit(input logic [IDX_W-1:0] idx);
        return PATTERN[idx];
    endfunction

    // Next-state and next-output logic; outputs describe the state being
    // entered so they appear registered on the following cycle.
    always_comb begin
        state_n     = state;
        bit_idx_n   = bit_idx;
        reps_left_n = reps_left;
        gap_cnt_n   = gap_cnt;
        out_n       = 1'b0;
        out_valid_n = 1'b0;
        last_n      = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    reps_left_n = rep_cnt;
                    if (rep_cnt != '0) begin
                        state_n     = SHIFT;
                        bit_idx_n   = TOP_IDX;
                        out_n       = pat_bit(TOP_IDX);
                        out_valid_n = 1'b1;
                    end else begin
                        state_n = DONE;
                    end
                end
            end

            SHIFT: begin
                if (abort) begin
                    state_n     = IDLE;
                    bit_idx_n   = '0;
                    reps_left_n = '0;
                    gap_cnt_n   = '0;
                end else if (bit_idx == '0) begin
                    // End of one repetition: finish, idle gap, or reload.
                    if (reps_left == REP_ONE) begin
                        state_n = DONE;
                    end else begin
                        reps_left_n = reps_left - REP_ONE;
                        if (HAS_GAP) begin
                            state_n   = GAP;
                            gap_cnt_n = GAP_LOAD;
                        end else begin
                            bit_idx_n   = TOP_IDX;
                            out_n       = pat_bit(TOP_IDX);
                            out_valid_n = 1'b1;
                        end
                    end
                end else begin
                    bit_idx_n   = bit_idx - IDX_ONE;
                    out_n       = pat_bit(bit_idx - IDX_ONE);
                    out_valid_n = 1'b1;
                    // Flag the final bit as it is loaded into the out flop.
                    last_n      = (bit_idx == IDX_ONE) && (reps_left == REP_ONE);
                end
            end

            GAP: begin
                if (abort) begin
                    state_n     = IDLE;
                    bit_idx_n   = '0;
                    reps_left_n = '0;
                    gap_cnt_n   = '0;
                end else if (gap_cnt == '0) begin
                    state_n     = SHIFT;
                    bit_idx_n   = TOP_IDX;
                    out_n       = pat_bit(TOP_IDX);
                    out_valid_n = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt - 4'd1;
                end
            end

            DONE: begin
                // abort and start are both ignored here; done always completes.
                state_n     = IDLE;
                bit_idx_n   = '0;
                reps_left_n = '0;
                gap_cnt_n   = '0;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        done_n = (state_n == DONE);
    end

    // State, counters and output flops; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bit_idx   <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            bit_idx   <= bit_idx_n;
            reps_left <= reps_left_n;
            gap_cnt   <= gap_cnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            last      <= last_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule

// File: tb/tb_sequence_generator_serial.sv
// Bench for sequence_generator_serial: instance 0 has no idle gap,
// instance 1 has a two-cycle gap. Stimulus pushes expected bits/done pulses
// into per-instance queues; a negedge monitor pops and compares.
module tb_sequence_generator_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, abort0, start1, abort1;
    logic [7:0] rep0, rep1;
    logic       out0, ov0, last0, busy0, done0;
    logic       out1, ov1, last1, busy1, done1;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        bit is_done;
        bit bitv;
        bit lastv;
        int cyc;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sequence_generator_serial #(
        .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .IDLE_GAP(0)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rep_cnt(rep0), .abort(abort0),
        .out(out0), .out_valid(ov0), .last(last0), .busy(busy0), .done(done0)
    );

    sequence_generator_serial #(
        .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8), .IDLE_GAP(2)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rep_cnt(rep1), .abort(abort1),
        .out(out1), .out_valid(ov1), .last(last1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int id, input exp_t e);
        if (id == 0) sb0.push_back(e);
        else         sb1.push_back(e);
    endtask

    task automatic mon(input int id, input logic o, input logic ov,
                       input logic l, input logic d);
        exp_t e;
        bit   have;
        if (ov) begin
            have = (id == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
                chk($sformatf("unexpected_bit_%0d", id), 1, 0);
            end else begin
                e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("kind_bit_%0d", id), 0, int'(e.is_done));
                chk($sformatf("out_%0d", id), int'(o), int'(e.bitv));
                chk($sformatf("last_%0d", id), int'(l), int'(e.lastv));
            end
        end else begin
            chk($sformatf("idle_out_last_%0d", id), int'({o, l}), 0);
        end
        if (d) begin
            chk($sformatf("done_with_valid_%0d", id), int'(ov), 0);
            have = (id == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
            if (!have) begin
                chk($sformatf("unexpected_done_%0d", id), 1, 0);
            end else begin
                e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("kind_done_%0d", id), 1, int'(e.is_done));
                chk($sformatf("done_cycle_%0d", id), cyc, e.cyc);
            end
        end
    endtask

    // Monitor: compare whatever each instance presents this cycle.
    always @(negedge clk) begin
        mon(0, out0, ov0, last0, done0);
        mon(1, out1, ov1, last1, done1);
    end

    // Drive a start request; s returns the cycle number of the sampling edge.
    task automatic issue(input int id, input int rep, output int s);
        @(negedge clk);
        if (id == 0) begin start0 = 1'b1; rep0 = 8'(rep); end
        else         begin start1 = 1'b1; rep1 = 8'(rep); end
        @(posedge clk);
        #1;
        s = cyc;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    // Expected bits of a run (first nbits of them) and optionally its done pulse.
    task automatic expect_run(input int id, input int rep, input int gap,
                              input int s, input int nbits, input bit with_done);
        logic [3:0] pat;
        exp_t       e;
        int         total;
        pat   = 4'b1011;
        total = rep * 4;
        for (int k = 0; k < total && k < nbits; k++) begin
            e.is_done = 1'b0;
            e.bitv    = pat[3 - (k % 4)];
            e.lastv   = (k == total - 1);
            e.cyc     = 0;
            push(id, e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.bitv    = 1'b0;
            e.lastv   = 1'b0;
            e.cyc     = (rep == 0) ? s : s + total + (rep - 1) * gap;
            push(id, e);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb0.size() > 0 || sb1.size() > 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("queues_drained", sb0.size() + sb1.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        rst = 1'b1;
        start0 = 1'b0; abort0 = 1'b0; rep0 = 8'd0;
        start1 = 1'b0; abort1 = 1'b0; rep1 = 8'd0;

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out", int'(out0), 0);
        chk("rst_out_valid", int'(ov0), 0);
        chk("rst_last", int'(last0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_done", int'(done0), 0);
        chk("rst_busy1", int'(busy1), 0);

        // Single repetition: 1,0,1,1 then done at start+4.
        issue(0, 1, s);
        expect_run(0, 1, 0, s, 1000, 1'b1);
        chk("busy_after_start", int'(busy0), 1);
        drain();
        chk("idle_after_run1", int'(busy0), 0);

        // Three back-to-back repetitions; a start mid-run must be ignored.
        issue(0, 3, s);
        expect_run(0, 3, 0, s, 1000, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start0 = 1'b1; rep0 = 8'd7;
        @(negedge clk);
        start0 = 1'b0;
        chk("busy_mid_run3", int'(busy0), 1);
        drain();
        chk("idle_after_run3", int'(busy0), 0);

        // Two repetitions with a two-cycle idle gap: done at start+10.
        issue(1, 2, s);
        expect_run(1, 2, 2, s, 1000, 1'b1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("gap_busy1", int'(busy1), 1);
        drain();
        chk("idle_after_gap_run", int'(busy1), 0);

        // Abort at the 6th bit; start in the same cycle is ignored.
        issue(0, 4, s);
        expect_run(0, 4, 0, s, 6, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        abort0 = 1'b1; start0 = 1'b1; rep0 = 8'd2;
        @(negedge clk);
        abort0 = 1'b0; start0 = 1'b0;
        chk("abort_valid", int'(ov0), 0);
        chk("abort_busy", int'(busy0), 0);
        repeat (10) @(negedge clk);
        chk("abort_stays_idle", int'(busy0), 0);
        drain();

        // A later start runs normally.
        issue(0, 1, s);
        expect_run(0, 1, 0, s, 1000, 1'b1);
        drain();

        // Zero repetitions: done on the cycle after the start edge, no bits;
        // start during DONE is ignored.
        issue(0, 0, s);
        expect_run(0, 0, 0, s, 1000, 1'b1);
        chk("rep0_busy_in_done", int'(busy0), 1);
        @(negedge clk);
        start0 = 1'b1; rep0 = 8'd1;
        @(negedge clk);
        start0 = 1'b0;
        chk("start_in_done_ignored", int'(busy0), 0);
        repeat (6) @(negedge clk);
        chk("still_idle_after_done_start", int'(busy0), 0);
        drain();

        // Maximum repetition count runs to completion without wrap.
        issue(0, 255, s);
        expect_run(0, 255, 0, s, 2000, 1'b1);
        drain();
        drain();

        // Reset in the middle of a pattern.
        issue(0, 2, s);
        expect_run(0, 2, 0, s, 2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", int'(ov0), 0);
        chk("rst_mid_busy", int'(busy0), 0);
        chk("rst_mid_out", int'(out0), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_mid_stays_idle", int'(busy0), 0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
